spm_seq_ctrl: RTL
=================

Name: spm_seq_ctrl

Overview:
Sequencer for the serial-parallel multiplier (spm) array, the chain of genblk1[*].csa carry-save cells.
- Accepts a parallel operand pair over a valid/ready handshake.
- Clears the array, presents the multiplicand in parallel and streams the multiplier LSB-first.
- Deserialises the serial product into a 2N-bit result returned over a second valid/ready handshake.
- Sits between the spm array and its host; it is the only driver of the array's x, y and clear inputs.

Parameters:
N, 32, operand width; equals the number of csa cells in the array; must be >= 2.
LAT, 1, array latency in cycles from spm_y driven to the matching spm_p bit; must be >= 0.
SIGNED, 1, 1 = two's-complement (multiplier sign-extended over 2N bits); 0 = unsigned (zero-extended).

Ports:
clk  in  1  clock; all state on the rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  controller can accept an operand pair.
in_a  in  N  multiplicand (parallel operand).
in_b  in  N  multiplier (serial operand).
out_valid  out  1  product valid.
out_ready  in  1  host accepts product.
out_p  out  2N  product.
spm_x  out  N  multiplicand to array, held for the whole operation.
spm_y  out  1  serial multiplier bit to array.
spm_clr  out  1  synchronous clear of array sum/carry flops.
spm_p  in  1  serial product bit from array.
busy  out  1  high in CLEAR and RUN.

Behaviour:
Reset (rst low, asynchronous):
- State goes to IDLE.
- in_ready=0 while rst is low, 1 on the first cycle after release.
- out_valid=0, out_p=0, spm_x=0, spm_y=0, spm_clr=0, busy=0.
- Counter and shift registers are cleared.

State machine (IDLE, CLEAR, RUN, DONE):
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_a into spm_x;
  - latch in_b into b_sr, a 2N-bit register with its upper N bits holding the sign of in_b when SIGNED=1, else 0;
  - go to CLEAR.
- CLEAR: exactly one cycle, spm_clr=1, in_ready=0; go to RUN with k=0.
- RUN: lasts 2N+LAT cycles, k=0..2N+LAT-1.
  - spm_y = b_sr[0] for k<2N; b_sr shifts right each cycle.
  - spm_y = 0 for k>=2N.
  - When k>=LAT, capture spm_p: p_sr <= {spm_p, p_sr[2N-1:1]}.
  - After cycle k=2N+LAT-1, go to DONE.
- DONE: out_valid=1 and out_p=p_sr, both held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - out_valid falls in the next cycle; out_p retains its value.

Rules:
- spm_x is stable from CLEAR through DONE; it changes only on input acceptance.
- in_ready=0 in CLEAR, RUN and DONE. There is no overlap of operations.
- Latency from input handshake to out_valid is 2N+LAT+2 cycles.
- The k counter is $clog2(2N+LAT+1) bits wide and never wraps within an operation.
- Product is modulo 2^(2N). For SIGNED=1 it is the exact two's-complement product of in_a*in_b.
- in_valid is ignored outside IDLE. in_a and in_b may change freely after acceptance.
- out_ready asserted when out_valid=0 has no effect.
- Reset mid-operation aborts immediately. The next operation after release starts with CLEAR, so no stale array state leaks.

Decomposition:
Shared package spm_pkg:
- state enum spm_state_e {IDLE, CLEAR, RUN, DONE};
- function spm_cnt_w(N,LAT) returning the counter width.

One natural sub-module: spm_piso_sipo, which holds the b serialiser and the p deserialiser shift registers with shared shift/load enables. The FSM and counter remain in spm_seq_ctrl.

Test Plan:
1. N=4, LAT=1, SIGNED=0: in_a=4'hF, in_b=4'hF, out_ready=1 -> out_p=8'hE1; out_valid rises exactly 2N+LAT+2=11 cycles after the handshake; spm_clr high exactly one cycle.
2. N=4, SIGNED=1: a=-1 (4'hF), b=-1 -> out_p=8'h01; a=4'h8 (-8), b=4'h7 -> out_p=8'hC8 (-56).
3. Back-pressure: out_ready=0 for 20 cycles after out_valid -> out_valid and out_p stay stable; in_ready=0 throughout; the second in_valid is not accepted until the cycle after the out_ready handshake.
4. Zero/identity, N=32 unsigned: a=0, b=32'hFFFFFFFF -> 0; a=1, b=32'h89ABCDEF -> 64'h0000000089ABCDEF; LAT=0 and LAT=3 builds give identical results.
5. Reset mid-RUN at k=3: rst low for one cycle -> all outputs 0 asynchronously, in_ready back to 1 after release; the next operation (a=3, b=5) yields 15 with no corruption from the aborted run.
6. Random 1000 ops, N=8, with a reference array model and random in_valid/out_ready gaps -> every out_p matches a*b (signed and unsigned builds); no operation lost or duplicated.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier sequencer.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } spm_state_e;

    // The RUN counter must hold the value 2N+LAT without wrapping.
    function automatic int spm_cnt_w(input int n, input int lat);
        return $clog2(2 * n + lat + 1);
    endfunction

endpackage

// File: rtl/spm_piso_sipo.sv
// Multiplier serialiser (LSB first, sign/zero extended to 2N bits) and
// product deserialiser for the spm sequencer.
module spm_piso_sipo
    import spm_pkg::*;
#(
    parameter int N      = 32,
    parameter int SIGNED = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load_i,
    input  logic [N-1:0]   b_i,
    input  logic           shift_i,
    input  logic           capture_i,
    input  logic           p_bit_i,
    output logic           y_o,
    output logic [2*N-1:0] p_o
);

    logic [2*N-1:0] b_sr_q, b_sr_d;
    logic [2*N-1:0] p_sr_q, p_sr_d;
    logic [N-1:0]   b_ext;

    assign b_ext = (SIGNED != 0) ? {N{b_i[N-1]}} : '0;

    always_comb begin
        b_sr_d = b_sr_q;
        p_sr_d = p_sr_q;
        if (load_i) begin
            b_sr_d = {b_ext, b_i};
        end else if (shift_i) begin
            b_sr_d = {1'b0, b_sr_q[2*N-1:1]};
        end
        // Product bits arrive LSB first, so they enter at the top and walk down.
        if (capture_i) begin
            p_sr_d = {p_bit_i, p_sr_q[2*N-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_sr_q <= '0;
            p_sr_q <= '0;
        end else begin
            b_sr_q <= b_sr_d;
            p_sr_q <= p_sr_d;
        end
    end

    assign y_o = b_sr_q[0];
    assign p_o = p_sr_q;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier array: operand handshake,
// array clear, serial multiplier stream and product handshake.
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter int N      = 32,
    parameter int LAT    = 1,
    parameter int SIGNED = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic [N-1:0]   spm_x,
    output logic           spm_y,
    output logic           spm_clr,
    input  logic           spm_p,
    output logic           busy
);

    localparam int CW = spm_cnt_w(N, LAT);
    localparam logic [CW-1:0] K_LAST = CW'(2 * N + LAT - 1);
    localparam logic [CW-1:0] K_YEND = CW'(2 * N);
    localparam logic [CW:0]   K_CAP1 = (CW + 1)'(LAT);

    spm_state_e    state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [N-1:0]  x_q, x_d;
    logic          rdy_q, rdy_d;

    logic load, shift, capture, y_en, y_raw;

    // in_ready is registered so it stays low throughout reset and rises
    // only on the first edge after release.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        x_d       = x_q;
        load      = 1'b0;
        shift     = 1'b0;
        capture   = 1'b0;
        y_en      = 1'b0;
        spm_clr   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    x_d     = in_a;
                    load    = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                spm_clr = 1'b1;
                busy    = 1'b1;
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                y_en    = (k_q < K_YEND);
                shift   = y_en;
                // Capture starts once the first product bit has crossed the array (k >= LAT).
                capture = (({1'b0, k_q} + 1'b1) > K_CAP1);
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            rdy_q   <= rdy_d;
        end
    end

    spm_piso_sipo #(
        .N      (N),
        .SIGNED (SIGNED)
    ) u_sr (
        .clk_i     (clk),
        .rst_ni    (rst),
        .load_i    (load),
        .b_i       (in_b),
        .shift_i   (shift),
        .capture_i (capture),
        .p_bit_i   (spm_p),
        .y_o       (y_raw),
        .p_o       (out_p)
    );

    assign spm_y    = y_en & y_raw;
    assign spm_x    = x_q;
    assign in_ready = rdy_q;

endmodule
